// File: rtl/rv_decode_stage.sv
// rv_decode_stage
// RV32I decode / operand-fetch stage feeding the integer logic/shift unit.
// Decodes OP and OP-IMM, reads a 32-entry register file with writeback
// bypass, and holds the result in a single-entry valid/ready output register.
module rv_decode_stage #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_ra,
    output logic [WIDTH-1:0] out_rb,
    output logic             out_alt,
    output logic [2:0]       out_funct3,
    output logic [4:0]       out_rd,
    output logic             out_is_lu,
    output logic             out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Register file (x0 entry exists but is never written and never read)
    logic [WIDTH-1:0] rf_q [NREGS];

    // Output register state and next-state
    logic             valid_q,   valid_d;
    logic [WIDTH-1:0] ra_q,      ra_d;
    logic [WIDTH-1:0] rb_q,      rb_d;
    logic             alt_q,     alt_d;
    logic [2:0]       funct3_q,  funct3_d;
    logic [4:0]       rd_q,      rd_d;
    logic             is_lu_q,   is_lu_d;
    logic             illegal_q, illegal_d;

    // Instruction fields
    logic [6:0] opcode_s;
    logic [6:0] funct7_s;
    logic [2:0] funct3_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    logic [4:0] rd_s;

    logic             wb_we_s;
    logic             accept_s;
    logic [WIDTH-1:0] rs1_val_s;
    logic [WIDTH-1:0] rs2_val_s;
    logic [WIDTH-1:0] imm_s;

    // Decoder outputs
    logic [WIDTH-1:0] dec_ra_s;
    logic [WIDTH-1:0] dec_rb_s;
    logic             dec_alt_s;
    logic             dec_legal_s;
    logic             dec_is_lu_s;

    assign opcode_s = in_instr[6:0];
    assign rd_s     = in_instr[11:7];
    assign funct3_s = in_instr[14:12];
    assign rs1_s    = in_instr[19:15];
    assign rs2_s    = in_instr[24:20];
    assign funct7_s = in_instr[31:25];
    assign imm_s    = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};

    assign wb_we_s  = wb_en && (wb_rd != 5'd0);

    // in_ready depends only on the output register, never on in_valid
    assign in_ready = !valid_q || out_ready;
    assign accept_s = in_valid && in_ready && !flush;

    // Register file write port; reset clears every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we_s) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // rs1 read port: x0 reads zero, a same-cycle writeback is forwarded
    always_comb begin
        rs1_val_s = '0;
        if (rs1_s == 5'd0) begin
            rs1_val_s = '0;
        end else if (wb_en && (wb_rd == rs1_s)) begin
            rs1_val_s = wb_data;
        end else begin
            rs1_val_s = rf_q[rs1_s];
        end
    end

    // rs2 read port: x0 reads zero, a same-cycle writeback is forwarded
    always_comb begin
        rs2_val_s = '0;
        if (rs2_s == 5'd0) begin
            rs2_val_s = '0;
        end else if (wb_en && (wb_rd == rs2_s)) begin
            rs2_val_s = wb_data;
        end else begin
            rs2_val_s = rf_q[rs2_s];
        end
    end

    // Decode OP / OP-IMM into operands, alt select and legality
    always_comb begin
        dec_ra_s    = '0;
        dec_rb_s    = '0;
        dec_alt_s   = 1'b0;
        dec_legal_s = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                dec_ra_s    = rs1_val_s;
                dec_rb_s    = rs2_val_s;
                dec_alt_s   = in_instr[30];
                dec_legal_s = (funct7_s == F7_ZERO) ||
                              ((funct7_s == F7_ALT) &&
                               ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec_ra_s = rs1_val_s;
                dec_rb_s = imm_s;
                case (funct3_s)
                    3'b001: begin
                        dec_alt_s   = 1'b0;
                        dec_legal_s = (funct7_s == F7_ZERO);
                    end
                    3'b101: begin
                        dec_alt_s   = in_instr[30];
                        dec_legal_s = (funct7_s == F7_ZERO) || (funct7_s == F7_ALT);
                    end
                    default: begin
                        dec_alt_s   = 1'b0;
                        dec_legal_s = 1'b1;
                    end
                endcase
            end
            default: begin
                // Not an integer ALU format: operands forced to zero
                dec_ra_s    = '0;
                dec_rb_s    = '0;
                dec_alt_s   = 1'b0;
                dec_legal_s = 1'b0;
            end
        endcase
    end

    // Logic/shift unit owns SLL, XOR, SRL/SRA, OR, AND (and their immediates)
    always_comb begin
        dec_is_lu_s = 1'b0;
        case (funct3_s)
            3'b001, 3'b100, 3'b101, 3'b110, 3'b111: dec_is_lu_s = dec_legal_s;
            default:                                dec_is_lu_s = 1'b0;
        endcase
    end

    // Next-state of the output register: flush drops, accept loads, consume empties
    always_comb begin
        valid_d   = valid_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        alt_d     = alt_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        is_lu_d   = is_lu_q;
        illegal_d = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d   = 1'b1;
            ra_d      = dec_ra_s;
            rb_d      = dec_rb_s;
            alt_d     = dec_alt_s;
            funct3_d  = funct3_s;
            rd_d      = rd_s;
            is_lu_d   = dec_is_lu_s;
            illegal_d = !dec_legal_s;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ra_q      <= '0;
            rb_q      <= '0;
            alt_q     <= 1'b0;
            funct3_q  <= 3'b000;
            rd_q      <= 5'd0;
            is_lu_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            alt_q     <= alt_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            is_lu_q   <= is_lu_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_ra      = ra_q;
    assign out_rb      = rb_q;
    assign out_alt     = alt_q;
    assign out_funct3  = funct3_q;
    assign out_rd      = rd_q;
    assign out_is_lu   = is_lu_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage
// Directed and randomized stimulus for rv_decode_stage, checked cycle by
// cycle against a behavioural model of the stage kept in the bench.
module tb_rv_decode_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, wb_en, out_ready;
    logic [31:0]      in_instr;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             in_ready, out_valid, out_alt, out_is_lu, out_illegal;
    logic [WIDTH-1:0] out_ra, out_rb;
    logic [2:0]       out_funct3;
    logic [4:0]       out_rd;

    always #5 clk = ~clk;

    rv_decode_stage #(.WIDTH(WIDTH), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ra(out_ra), .out_rb(out_rb), .out_alt(out_alt),
        .out_funct3(out_funct3), .out_rd(out_rd),
        .out_is_lu(out_is_lu), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [31:0] ra;
        logic [31:0] rb;
        logic        alt;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        lu;
        logic        ill;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    bit          model_on = 1'b0;
    logic        m_valid;
    exp_t        m_out;
    logic [31:0] m_rf [32];
    int          n_acc = 0;
    int          n_cons = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // What the architecture says an instruction means, given register values
    function automatic exp_t model_decode(input logic [31:0] ins,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        exp_t       e;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       legal;
        f7 = ins[31:25];
        f3 = ins[14:12];
        e = '0;
        e.f3 = f3;
        e.rd = ins[11:7];
        if (ins[6:0] == 7'h33) begin
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.ra = a;
            e.rb = b;
            e.alt = ins[30];
        end else if (ins[6:0] == 7'h13) begin
            if (f3 == 3'd1)      legal = (f7 == 7'h00);
            else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else                 legal = 1'b1;
            e.ra = a;
            e.rb = 32'($signed(ins[31:20]));
            e.alt = (f3 == 3'd5) ? ins[30] : 1'b0;
        end else begin
            legal = 1'b0;
        end
        e.ill = !legal;
        e.lu  = legal && (f3 inside {3'd1, 3'd4, 3'd5, 3'd6, 3'd7});
        return e;
    endfunction

    // One clock: compare DUT to model, advance model with the current inputs, tick
    task automatic cycle();
        logic [31:0] rf_next [32];
        logic        acc;
        logic        exp_ready;
        #1;
        exp_ready = !m_valid || out_ready;
        if (model_on) begin
            chk("in_ready",   {31'd0, in_ready},    {31'd0, exp_ready});
            chk("out_valid",  {31'd0, out_valid},   {31'd0, m_valid});
            chk("out_ra",     out_ra,               m_out.ra);
            chk("out_rb",     out_rb,               m_out.rb);
            chk("out_alt",    {31'd0, out_alt},     {31'd0, m_out.alt});
            chk("out_funct3", {29'd0, out_funct3},  {29'd0, m_out.f3});
            chk("out_rd",     {27'd0, out_rd},      {27'd0, m_out.rd});
            chk("out_is_lu",  {31'd0, out_is_lu},   {31'd0, m_out.lu});
            chk("out_ill",    {31'd0, out_illegal}, {31'd0, m_out.ill});
        end
        // Operands see the register file as it stands after this cycle's writeback
        for (int i = 0; i < 32; i++) rf_next[i] = m_rf[i];
        if (wb_en) rf_next[wb_rd] = wb_data;
        rf_next[0] = 32'd0;
        if (rst) begin
            model_on = 1'b1;
            m_valid  = 1'b0;
            m_out    = '0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else begin
            acc = in_valid && exp_ready && !flush;
            if (m_valid && out_ready && !flush) n_cons++;
            if (acc) begin
                n_acc++;
                m_out   = model_decode(in_instr, rf_next[in_instr[19:15]], rf_next[in_instr[24:20]]);
                m_valid = 1'b1;
            end else if (flush || out_ready) begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < 32; i++) m_rf[i] = rf_next[i];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = r; wb_data = d;
        cycle();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins);
        in_valid = 1'b1; in_instr = ins;
        cycle();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k <= 3) begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 2))
                0:       w[31:25] = 7'h00;
                1:       w[31:25] = 7'h20;
                default: w[31:25] = 7'($urandom);
            endcase
        end else if (k <= 7) begin
            w[6:0] = 7'h13;
            if ($urandom_range(0, 1) == 0) w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        end else if (k == 8) begin
            w[6:0] = 7'h03;
        end
        return w;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
        cycle();
        rst = 1'b0;
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_ra", out_ra, 32'd0);

        // SRA x7,x5,x6
        wb(5'd5, 32'h8000_0000);
        wb(5'd6, 32'd4);
        issue(32'h4062_D3B3);
        chk("sra_valid", {31'd0, out_valid}, 32'd1);
        chk("sra_ra", out_ra, 32'h8000_0000);
        chk("sra_rb", out_rb, 32'd4);
        chk("sra_alt", {31'd0, out_alt}, 32'd1);
        chk("sra_f3", {29'd0, out_funct3}, 32'd5);
        chk("sra_rd", {27'd0, out_rd}, 32'd7);
        chk("sra_lu", {31'd0, out_is_lu}, 32'd1);

        // SRAI x1,x2,31 then ANDI x1,x2,-1
        wb(5'd2, 32'h0000_00F0);
        issue(32'h41F1_5093);
        chk("srai_ra", out_ra, 32'h0000_00F0);
        chk("srai_rb", out_rb, 32'h0000_041F);
        chk("srai_alt", {31'd0, out_alt}, 32'd1);
        issue(32'hFFF1_7093);
        chk("andi_rb", out_rb, 32'hFFFF_FFFF);
        chk("andi_alt", {31'd0, out_alt}, 32'd0);
        chk("andi_f3", {29'd0, out_funct3}, 32'd7);

        // Bypass: XOR x4,x3,x0 in the same cycle as the x3 writeback
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_1234;
        issue(32'h0001_C233);
        wb_en = 1'b0;
        chk("byp_ra", out_ra, 32'h0000_1234);
        chk("byp_rb", out_rb, 32'd0);

        // Writes to x0 are ignored: ADD x1,x0,x0
        wb(5'd0, 32'h0000_FFFF);
        issue(32'h0000_00B3);
        chk("x0_ra", out_ra, 32'd0);
        chk("x0_rb", out_rb, 32'd0);

        // Back-pressure: held op must stay put while a new one waits
        issue(32'h0031_60B3);
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000_C0B3;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_f3", {29'd0, out_funct3}, 32'd6);
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("bp_load_f3", {29'd0, out_funct3}, 32'd4);

        // Illegal forms
        issue(32'h4000_1093);
        chk("slli_ill", {31'd0, out_illegal}, 32'd1);
        chk("slli_lu", {31'd0, out_is_lu}, 32'd0);
        issue(32'h0001_2083);
        chk("load_ill", {31'd0, out_illegal}, 32'd1);
        chk("load_lu", {31'd0, out_is_lu}, 32'd0);
        chk("load_ra", out_ra, 32'd0);

        // Flush while holding, with a simultaneous offer
        out_ready = 1'b0;
        issue(32'h0031_60B3);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_C0B3;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);

        // Random stream with back-pressure, writebacks and rare flushes
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            wb_en     = ($urandom_range(0, 1) == 1);
            wb_rd     = 5'($urandom);
            wb_data   = $urandom;
            cycle();
        end
        in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        cycle();
        chk("stream_ops", (n_acc >= 20) ? 32'd1 : 32'd0, 32'd1);

        // Reset mid-stream clears outputs and the register file
        in_valid = 1'b1; in_instr = 32'h0031_60B3; out_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_f3", {29'd0, out_funct3}, 32'd0);
        issue(32'h0031_60B3);
        chk("rst2_ra", out_ra, 32'd0);
        chk("rst2_rb", out_rb, 32'd0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
